// File: rtl/io_freeze_ctrl_if.sv
// Bundle between the CPU-side output register, the freeze controller and the pad layer.
// The controller takes the slave view; the driver of wfi/led_bus takes the master view.
interface io_freeze_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             wfi;
  logic [WIDTH-1:0] led_bus;
  logic [WIDTH-1:0] pad_dout;
  logic [WIDTH-1:0] pad_oe;
  logic             frozen;
  logic             wake_pulse;

  modport master (
    output wfi, led_bus,
    input  pad_dout, pad_oe, frozen, wake_pulse
  );

  modport slave (
    input  wfi, led_bus,
    output pad_dout, pad_oe, frozen, wake_pulse
  );
endinterface

// File: rtl/io_freeze_ctrl.sv
// Registered pad output stage that gates masked channels while the CPU idles in WFI.
// Define IO_FREEZE_PARK_EN to drive PARK_VAL on masked channels instead of tri-stating them.
module io_freeze_ctrl #(
  parameter int               WIDTH       = 8,
  parameter int               ENTRY_DLY   = 4,
  parameter int               EXIT_DLY    = 2,
  parameter logic [WIDTH-1:0] FREEZE_MASK = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] PARK_VAL    = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  io_freeze_ctrl_if.slave  bus
);

  localparam int MAX_DLY = (ENTRY_DLY > EXIT_DLY) ? ENTRY_DLY : EXIT_DLY;
  localparam int CW      = $clog2(MAX_DLY + 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW:0]   ENTRY_LAST = (CW+1)'(ENTRY_DLY);
  localparam logic [CW:0]   EXIT_LAST  = (CW+1)'(EXIT_DLY);

  typedef enum logic [1:0] {ACTIVE, ENTER, FROZEN, EXIT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_sat;
  logic [CW:0]      cnt_inc;
  logic [WIDTH-1:0] snapshot_reg, snapshot_next;
  logic [WIDTH-1:0] pad_dout_reg, pad_dout_next;
  logic [WIDTH-1:0] pad_oe_reg, pad_oe_next;
  logic             frozen_reg, frozen_next;
  logic             wake_reg, wake_next;
  logic             gated_next;

  // cnt_inc is one bit wider so the compare against the delay never aliases.
  assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
  assign cnt_sat = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    snapshot_next = snapshot_reg;
    case (state_reg)
      ACTIVE: begin
        if (bus.wfi) begin
          cnt_next = CW'(1);
          if (ENTRY_DLY == 1) begin
            state_next    = FROZEN;
            snapshot_next = bus.led_bus;
          end else begin
            state_next = ENTER;
          end
        end else begin
          cnt_next = '0;
        end
      end
      ENTER: begin
        if (!bus.wfi) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_sat;
          if (cnt_inc == ENTRY_LAST) begin
            state_next    = FROZEN;
            snapshot_next = bus.led_bus;
          end
        end
      end
      FROZEN: begin
        if (!bus.wfi) begin
          cnt_next   = CW'(1);
          state_next = (EXIT_DLY == 1) ? ACTIVE : EXIT;
        end else begin
          cnt_next = '0;
        end
      end
      EXIT: begin
        if (bus.wfi) begin
          state_next = FROZEN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_sat;
          if (cnt_inc == EXIT_LAST) state_next = ACTIVE;
        end
      end
      default: begin
        state_next = ACTIVE;
        cnt_next   = '0;
      end
    endcase
  end

  assign gated_next  = (state_next == FROZEN) || (state_next == EXIT);
  assign frozen_next = gated_next;
  assign wake_next   = ((state_reg == FROZEN) || (state_reg == EXIT)) && (state_next == ACTIVE);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      if (FREEZE_MASK[gi]) begin : g_masked
`ifdef IO_FREEZE_PARK_EN
        assign pad_dout_next[gi] = gated_next ? PARK_VAL[gi] : bus.led_bus[gi];
        assign pad_oe_next[gi]   = 1'b1;
`else
        // snapshot_next already equals led_bus on the entry edge, so one mux covers both cases.
        assign pad_dout_next[gi] = gated_next ? snapshot_next[gi] : bus.led_bus[gi];
        assign pad_oe_next[gi]   = ~gated_next;
`endif
      end else begin : g_plain
        assign pad_dout_next[gi] = bus.led_bus[gi];
        assign pad_oe_next[gi]   = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACTIVE;
      cnt_reg      <= '0;
      snapshot_reg <= '0;
      pad_dout_reg <= '0;
      pad_oe_reg   <= '1;
      frozen_reg   <= 1'b0;
      wake_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      snapshot_reg <= snapshot_next;
      pad_dout_reg <= pad_dout_next;
      pad_oe_reg   <= pad_oe_next;
      frozen_reg   <= frozen_next;
      wake_reg     <= wake_next;
    end
  end

  assign bus.pad_dout   = pad_dout_reg;
  assign bus.pad_oe     = pad_oe_reg;
  assign bus.frozen     = frozen_reg;
  assign bus.wake_pulse = wake_reg;

endmodule
